// File: rtl/braille_pkg.sv
`default_nettype none
// ============================================================================
// Module : braille_pkg
// Brief  : Shared cell type, FSM states and the 6-dot digit cell table.
// Rev    : 1.0
// ============================================================================
package braille_pkg;

  typedef logic [5:0] cell_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SIGN  = 2'd1,
    DIGIT = 2'd2
  } state_t;

  localparam cell_t CELL_NUM_SIGN = 6'h3C;
  localparam cell_t CELL_ERR      = 6'h3F;
  localparam cell_t CELL_BLANK    = 6'h00;

  // Entry k is the cell for digit k; entry 9 is written first.
  localparam logic [9:0][5:0] DIGIT_CELL_TBL = {
    6'h0A, 6'h13, 6'h1B, 6'h0B, 6'h11,
    6'h19, 6'h09, 6'h03, 6'h01, 6'h1A
  };

endpackage
`default_nettype wire

// File: rtl/braille_digit_cell.sv
`default_nettype none
// ============================================================================
// Module : braille_digit_cell
// Brief  : Combinational BCD digit to 6-dot Braille cell, flags values > 9.
// Rev    : 1.0
// ============================================================================
module braille_digit_cell
  import braille_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [5:0] cell_o,
  output logic       err_o
);

  always_comb begin
    cell_o = CELL_ERR;
    err_o  = 1'b1;
    if (bcd_i <= 4'd9) begin
      cell_o = DIGIT_CELL_TBL[bcd_i];
      err_o  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/braille_number_serializer.sv
`default_nettype none
// ============================================================================
// Module : braille_number_serializer
// Brief  : Serialises a packed BCD number into 6-dot Braille cells, MSD first.
// Rev    : 1.0
// ============================================================================
module braille_number_serializer
  import braille_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter bit EMIT_SIGN   = 1'b1,
  parameter bit SUPPRESS_LZ = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] in_bcd,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [5:0]              out_cell,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    out_err
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BCD_W = 4 * NUM_DIGITS;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t MSD_IDX = idx_t'(NUM_DIGITS - 1);

  state_t             state_q, state_d;
  idx_t               idx_q, idx_d;
  idx_t               start_q, start_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  cell_t              cell_q, cell_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               err_q, err_d;

  idx_t               start_idx;
  logic [3:0]         digit_sel;
  cell_t              digit_cell;
  logic               digit_err;

  // Highest non-zero digit wins; invalid digits (A..F) count as non-zero.
  always_comb begin
    start_idx = MSD_IDX;
    if (SUPPRESS_LZ) begin
      start_idx = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (in_bcd[4*k +: 4] != 4'd0) begin
          start_idx = idx_t'(k);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    start_d = start_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bcd_d   = in_bcd;
          start_d = start_idx;
          idx_d   = start_idx;
          state_d = EMIT_SIGN ? SIGN : DIGIT;
        end
      end
      SIGN: begin
        if (out_ready) begin
          state_d = DIGIT;
          idx_d   = start_q;
        end
      end
      DIGIT: begin
        if (out_ready) begin
          if (idx_q == '0) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q - idx_t'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so the cell is looked up from next-state values.
  always_comb begin
    digit_sel = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == idx_t'(k)) begin
        digit_sel = bcd_d[4*k +: 4];
      end
    end
  end

  braille_digit_cell u_digit_cell (
    .bcd_i  (digit_sel),
    .cell_o (digit_cell),
    .err_o  (digit_err)
  );

  always_comb begin
    cell_d  = CELL_BLANK;
    valid_d = 1'b0;
    last_d  = 1'b0;
    err_d   = 1'b0;
    case (state_d)
      SIGN: begin
        cell_d  = CELL_NUM_SIGN;
        valid_d = 1'b1;
      end
      DIGIT: begin
        cell_d  = digit_cell;
        valid_d = 1'b1;
        last_d  = (idx_d == '0);
        err_d   = digit_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      start_q <= '0;
      bcd_q   <= '0;
      cell_q  <= CELL_BLANK;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      bcd_q   <= bcd_d;
      cell_q  <= cell_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_cell  = cell_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_braille_number_serializer.sv
`default_nettype none
// ============================================================================
// Module : tb_braille_number_serializer
// Brief  : Directed vector bench over four parameter configurations.
// Rev    : 1.0
// ============================================================================
module tb_braille_number_serializer;

  // DUT 0: defaults, 1: SUPPRESS_LZ=0, 2: EMIT_SIGN=0, 3: NUM_DIGITS=1
  logic        clk;
  logic        reset;
  logic [15:0] in_bcd    [4];
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic [5:0]  out_cell  [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic        out_last  [4];
  logic        out_err   [4];

  int n_vec;
  int n_miss;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  braille_number_serializer u_dut0 (
    .clk(clk), .reset(reset), .in_bcd(in_bcd[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_cell(out_cell[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_last(out_last[0]), .out_err(out_err[0]));

  braille_number_serializer #(.SUPPRESS_LZ(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .in_bcd(in_bcd[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_cell(out_cell[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_last(out_last[1]), .out_err(out_err[1]));

  braille_number_serializer #(.EMIT_SIGN(1'b0)) u_dut2 (
    .clk(clk), .reset(reset), .in_bcd(in_bcd[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .out_cell(out_cell[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_last(out_last[2]), .out_err(out_err[2]));

  braille_number_serializer #(.NUM_DIGITS(1)) u_dut3 (
    .clk(clk), .reset(reset), .in_bcd(in_bcd[3][3:0]), .in_valid(in_valid[3]),
    .in_ready(in_ready[3]), .out_cell(out_cell[3]), .out_valid(out_valid[3]),
    .out_ready(out_ready[3]), .out_last(out_last[3]), .out_err(out_err[3]));

  typedef struct {
    int          dut;
    logic [15:0] bcd;
    int          n;
    logic [29:0] cells;  // cell 0 in the top six bits
    logic [4:0]  errs;   // bit i flags cell i
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_cell(input string tag, input int d, input logic [5:0] c,
                          input logic l, input logic e);
    chk({tag, " valid"}, 32'(out_valid[d]), 32'd1);
    chk({tag, " cell"},  32'(out_cell[d]),  32'(c));
    chk({tag, " last"},  32'(out_last[d]),  32'(l));
    chk({tag, " err"},   32'(out_err[d]),   32'(e));
  endtask

  task automatic run_vector(input int d, input logic [15:0] bcd, input int n,
                            input logic [29:0] cells, input logic [4:0] errs,
                            input string tag);
    chk({tag, " ready_in"}, 32'(in_ready[d]), 32'd1);
    in_bcd[d]    = bcd;
    in_valid[d]  = 1'b1;
    out_ready[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk_cell($sformatf("%s c%0d", tag, i), d, cells[29-6*i -: 6],
               (i == n - 1), errs[i]);
      @(negedge clk);
    end
    chk({tag, " bubble"}, 32'(out_valid[d]), 32'd0);
    chk({tag, " ready_after"}, 32'(in_ready[d]), 32'd1);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b1;
    for (int d = 0; d < 4; d++) begin
      in_bcd[d]    = 16'h0;
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
    end

    vecs[0] = '{0, 16'h0305, 4, {6'h3C, 6'h09, 6'h1A, 6'h11, 6'h00}, 5'b00000};
    vecs[1] = '{0, 16'h0000, 2, {6'h3C, 6'h1A, 6'h00, 6'h00, 6'h00}, 5'b00000};
    vecs[2] = '{1, 16'h0000, 5, {6'h3C, 6'h1A, 6'h1A, 6'h1A, 6'h1A}, 5'b00000};
    vecs[3] = '{0, 16'h1C90, 5, {6'h3C, 6'h01, 6'h3F, 6'h0A, 6'h1A}, 5'b00100};
    vecs[4] = '{2, 16'h7681, 4, {6'h1B, 6'h0B, 6'h13, 6'h01, 6'h00}, 5'b00000};
    vecs[5] = '{2, 16'h0009, 1, {6'h0A, 6'h00, 6'h00, 6'h00, 6'h00}, 5'b00000};
    vecs[6] = '{3, 16'h0008, 2, {6'h3C, 6'h13, 6'h00, 6'h00, 6'h00}, 5'b00000};
    vecs[7] = '{1, 16'h0305, 5, {6'h3C, 6'h1A, 6'h09, 6'h1A, 6'h11}, 5'b00000};
    vecs[8] = '{0, 16'h0F00, 4, {6'h3C, 6'h3F, 6'h1A, 6'h1A, 6'h00}, 5'b00010};

    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst%0d in_ready", d),  32'(in_ready[d]),  32'd1);
      chk($sformatf("rst%0d out_valid", d), 32'(out_valid[d]), 32'd0);
      chk($sformatf("rst%0d out_cell", d),  32'(out_cell[d]),  32'd0);
      chk($sformatf("rst%0d out_last", d),  32'(out_last[d]),  32'd0);
      chk($sformatf("rst%0d out_err", d),   32'(out_err[d]),   32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      run_vector(vecs[v].dut, vecs[v].bcd, vecs[v].n, vecs[v].cells, vecs[v].errs,
                 $sformatf("vec%0d", v));
      @(negedge clk);
    end

    // Backpressure: each cell stalls three cycles; inputs offered meanwhile are refused.
    begin
      logic [17:0] bp_cells;
      bp_cells = {6'h3C, 6'h19, 6'h03};
      in_bcd[0]    = 16'h0042;
      in_valid[0]  = 1'b1;
      out_ready[0] = 1'b0;
      @(negedge clk);
      in_valid[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        repeat (3) begin
          chk_cell($sformatf("bp stall c%0d", i), 0, bp_cells[17-6*i -: 6], (i == 2), 1'b0);
          chk($sformatf("bp c%0d in_ready", i), 32'(in_ready[0]), 32'd0);
          in_bcd[0]   = 16'h0999;
          in_valid[0] = 1'b1;
          @(negedge clk);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        chk_cell($sformatf("bp xfer c%0d", i), 0, bp_cells[17-6*i -: 6], (i == 2), 1'b0);
        @(negedge clk);
        out_ready[0] = 1'b0;
      end
      chk("bp bubble", 32'(out_valid[0]), 32'd0);
      chk("bp ready_after", 32'(in_ready[0]), 32'd1);
      out_ready[0] = 1'b1;
      @(negedge clk);
    end

    // Reset while the second cell is presented aborts the number.
    in_bcd[2]   = 16'h7681;
    in_valid[2] = 1'b1;
    @(negedge clk);
    in_valid[2] = 1'b0;
    chk_cell("rstmid c0", 2, 6'h1B, 1'b0, 1'b0);
    @(negedge clk);
    chk_cell("rstmid c1", 2, 6'h0B, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid out_valid", 32'(out_valid[2]), 32'd0);
    chk("rstmid in_ready", 32'(in_ready[2]), 32'd1);
    chk("rstmid out_cell", 32'(out_cell[2]), 32'd0);
    run_vector(2, 16'h0009, 1, {6'h0A, 24'h0}, 5'b0, "rstmid next");
    @(negedge clk);

    // Back-to-back numbers on the one-digit build: one bubble between them.
    in_bcd[3]   = 16'h0008;
    in_valid[3] = 1'b1;
    @(negedge clk);
    chk_cell("b2b n0 c0", 3, 6'h3C, 1'b0, 1'b0);
    chk("b2b n0 in_ready", 32'(in_ready[3]), 32'd0);
    @(negedge clk);
    chk_cell("b2b n0 c1", 3, 6'h13, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b bubble", 32'(out_valid[3]), 32'd0);
    chk("b2b bubble in_ready", 32'(in_ready[3]), 32'd1);
    @(negedge clk);
    in_valid[3] = 1'b0;
    chk_cell("b2b n1 c0", 3, 6'h3C, 1'b0, 1'b0);
    @(negedge clk);
    chk_cell("b2b n1 c1", 3, 6'h13, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b end", 32'(out_valid[3]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
